tug_of_war_field: RTL and testbench

- Parametrised tug-of-war playfield. Replaces per-LED light cells with one position register driving an N-light one-hot display.
- Adds key edge detection, win detection, per-side saturating scores, a timed win display and a game-over state.
- Sits between the synchronised key inputs and the LED/HEX drivers. Score outputs feed the seven-segment decoders.

---
 rtl/tug_of_war_field.sv | 174 +++++++++++++++++
 tb/tb_tug_of_war_field.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: one position register drives an N-light one-hot
// display. It adds key edge detection, round wins with per-side saturating
// scores, a timed win display and a game-over state.
// Optional macro CPU_OPPONENT_EN: an internal LFSR opponent replaces the R key.
module tug_of_war_field #(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
`ifdef CPU_OPPONENT_EN
  , parameter logic [9:0] CPU_THRESHOLD = 10'd200
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  input  logic                  resetround,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]    left_score,
  output logic [SCORE_W-1:0]    right_score,
  output logic [1:0]            winner,
  output logic                  round_done
);

  // state    | meaning
  // PLAY     | light moves on key presses
  // HOLD     | winner's end light shown for HOLD_CYCLES clocks
  // GAMEOVER | winner's half lit until reset
  typedef enum logic [1:0] {PLAY, HOLD, GAMEOVER} state_t;

  localparam int POS_W  = $clog2(NUM_LIGHTS);
  localparam int CNT_W  = $clog2(HOLD_CYCLES + 1);
  localparam int CENTER_I = (NUM_LIGHTS - 1) / 2;
  localparam logic [POS_W-1:0]   CENTER    = POS_W'(CENTER_I);
  localparam logic [POS_W-1:0]   LAST      = POS_W'(NUM_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t             state, state_nxt;
  logic [POS_W-1:0]   pos, pos_nxt;
  logic [SCORE_W-1:0] lscore_nxt, rscore_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               left_won, left_won_nxt;
  logic               done_nxt;
  logic               l_q, r_q;
  logic               r_src;
  logic               p_l, p_r;

`ifdef CPU_OPPONENT_EN
  logic [9:0] lfsr;
  logic       unused_r;
  assign unused_r = R;

  // Fibonacci LFSR, taps 10 and 7, free-running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 10'h001;
    else       lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  end

  assign r_src = (lfsr < CPU_THRESHOLD);
`else
  assign r_src = R;
`endif

  assign p_l = L & ~l_q;
  assign p_r = r_src & ~r_q;

  // Key history updates in every state so a key held across HOLD never re-fires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_q <= 1'b0;
      r_q <= 1'b0;
    end else begin
      l_q <= L;
      r_q <= r_src;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PLAY;
      pos         <= CENTER;
      left_score  <= '0;
      right_score <= '0;
      cnt         <= '0;
      left_won    <= 1'b0;
      round_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      left_score  <= lscore_nxt;
      right_score <= rscore_nxt;
      cnt         <= cnt_nxt;
      left_won    <= left_won_nxt;
      round_done  <= done_nxt;
    end
  end

  // Next-state logic: movement, round wins, hold timing
  always_comb begin
    state_nxt    = state;
    pos_nxt      = pos;
    lscore_nxt   = left_score;
    rscore_nxt   = right_score;
    cnt_nxt      = cnt;
    left_won_nxt = left_won;
    done_nxt     = 1'b0;
    unique case (state)
      PLAY: begin
        if (resetround) begin
          pos_nxt = CENTER;
        end else if (p_l && !p_r) begin
          if (pos == LAST) begin
            lscore_nxt   = (left_score == SCORE_MAX) ? left_score : left_score + SCORE_W'(1);
            left_won_nxt = 1'b1;
            done_nxt     = 1'b1;
            cnt_nxt      = HOLD_LOAD;
            state_nxt    = HOLD;
          end else begin
            pos_nxt = pos + POS_W'(1);
          end
        end else if (p_r && !p_l) begin
          if (pos == '0) begin
            rscore_nxt   = (right_score == SCORE_MAX) ? right_score : right_score + SCORE_W'(1);
            left_won_nxt = 1'b0;
            done_nxt     = 1'b1;
            cnt_nxt      = HOLD_LOAD;
            state_nxt    = HOLD;
          end else begin
            pos_nxt = pos - POS_W'(1);
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if ((left_won ? left_score : right_score) >= WIN_VAL) begin
            state_nxt = GAMEOVER;
          end else begin
            state_nxt = PLAY;
            pos_nxt   = CENTER;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAMEOVER: state_nxt = GAMEOVER;
      default:  state_nxt = PLAY;
    endcase
  end

  // Display decode and winner encoding
  always_comb begin
    lights = '0;
    winner = 2'b00;
    unique case (state)
      PLAY: lights[pos] = 1'b1;
      HOLD: begin
        if (left_won) lights[NUM_LIGHTS-1] = 1'b1;
        else          lights[0] = 1'b1;
      end
      GAMEOVER: begin
        for (int i = 0; i < NUM_LIGHTS; i++) begin
          if (left_won ? (i > CENTER_I) : (i < CENTER_I)) lights[i] = 1'b1;
        end
        winner = left_won ? 2'b10 : 2'b01;
      end
      default: lights = '0;
    endcase
  end

endmodule

// File: tb/tb_tug_of_war_field.sv
// Scoreboard bench for tug_of_war_field: a 9-light default instance and a
// 5-light instance (HOLD_CYCLES=2, WIN_SCORE=2) checked against a behavioural model.
module tb_tug_of_war_field;

  logic clk = 1'b0;
  logic rst;
  logic l9, r9, rr9;
  logic l5, r5, rr5;
  logic [8:0] lights9;
  logic [2:0] ls9, rs9;
  logic [1:0] win9;
  logic       done9;
  logic [4:0] lights5;
  logic [2:0] ls5, rs5;
  logic [1:0] win5;
  logic       done5;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tug_of_war_field dut9 (
    .clk(clk), .reset(rst), .L(l9), .R(r9), .resetround(rr9),
    .lights(lights9), .left_score(ls9), .right_score(rs9),
    .winner(win9), .round_done(done9)
  );

  tug_of_war_field #(.NUM_LIGHTS(5), .SCORE_W(3), .WIN_SCORE(2), .HOLD_CYCLES(2)) dut5 (
    .clk(clk), .reset(rst), .L(l5), .R(r5), .resetround(rr5),
    .lights(lights5), .left_score(ls5), .right_score(rs5),
    .winner(win5), .round_done(done5)
  );

  typedef struct {
    string      tag;
    logic [4:0] lights;
    logic [2:0] ls;
    logic [2:0] rs;
    logic [1:0] win;
    logic       done;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] sb9[$];

  // behavioural model of the 5-light instance
  int   m_state;   // 0 play, 1 hold, 2 game over
  int   m_pos;
  int   m_ls, m_rs;
  int   m_cnt;
  logic m_left, m_done, m_lq, m_rq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 2; m_ls = 0; m_rs = 0; m_cnt = 0;
    m_left = 1'b0; m_done = 1'b0; m_lq = 1'b0; m_rq = 1'b0;
  endtask

  task automatic model_step(input logic l, input logic r, input logic rr);
    logic pl, pr;
    pl = l & ~m_lq;
    pr = r & ~m_rq;
    m_done = 1'b0;
    if (m_state == 0) begin
      if (rr) m_pos = 2;
      else if (pl && !pr) begin
        if (m_pos == 4) begin
          m_ls = (m_ls < 7) ? m_ls + 1 : 7;
          m_left = 1'b1; m_done = 1'b1; m_cnt = 1; m_state = 1;
        end else m_pos++;
      end else if (pr && !pl) begin
        if (m_pos == 0) begin
          m_rs = (m_rs < 7) ? m_rs + 1 : 7;
          m_left = 1'b0; m_done = 1'b1; m_cnt = 1; m_state = 1;
        end else m_pos--;
      end
    end else if (m_state == 1) begin
      if (m_cnt == 0) begin
        if ((m_left ? m_ls : m_rs) >= 2) m_state = 2;
        else begin m_state = 0; m_pos = 2; end
      end else m_cnt--;
    end
    m_lq = l;
    m_rq = r;
  endtask

  function automatic exp_t model_out(input string tag);
    exp_t e;
    e.tag = tag;
    e.ls = 3'(m_ls);
    e.rs = 3'(m_rs);
    e.done = m_done;
    e.win = 2'b00;
    case (m_state)
      0: e.lights = 5'b00001 << m_pos;
      1: e.lights = m_left ? 5'b10000 : 5'b00001;
      default: begin
        e.lights = m_left ? 5'b11000 : 5'b00011;
        e.win = m_left ? 2'b10 : 2'b01;
      end
    endcase
    return e;
  endfunction

  task automatic compare5();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".lights"}, 32'(lights5), 32'(e.lights));
    check({e.tag, ".lscore"}, 32'(ls5), 32'(e.ls));
    check({e.tag, ".rscore"}, 32'(rs5), 32'(e.rs));
    check({e.tag, ".winner"}, 32'(win5), 32'(e.win));
    check({e.tag, ".done"}, 32'(done5), 32'(e.done));
  endtask

  task automatic step(input string tag, input logic l, input logic r, input logic rr);
    l5 = l; r5 = r; rr5 = rr;
    model_step(l, r, rr);
    sb.push_back(model_out(tag));
    @(posedge clk);
    #1;
    compare5();
  endtask

  task automatic press_l(input string tag);
    step(tag, 1'b1, 1'b0, 1'b0);
    step({tag, "_rel"}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_r(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0);
    step({tag, "_rel"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    l9 = 1'b0; r9 = 1'b0; rr9 = 1'b0;
    l5 = 1'b0; r5 = 1'b0; rr5 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(model_out("reset"));
    compare5();
    sb9.push_back(9'b000010000);
    check("reset9.lights", 32'(lights9), 32'(sb9.pop_front()));
    check("reset9.scores", 32'({ls9, rs9, win9, done9}), 32'd0);
    rst = 1'b0;

    // held key on the 9-light field moves exactly once
    l9 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb9.push_back(9'b000100000);
      @(posedge clk);
      #1;
      check("hold9.lights", 32'(lights9), 32'(sb9.pop_front()));
    end
    l9 = 1'b0;

    // left wins a round; L held through HOLD and into PLAY must not move the light
    press_l("l_move1");
    press_l("l_move2");
    step("l_win", 1'b1, 1'b0, 1'b0);
    step("hold_a", 1'b1, 1'b0, 1'b0);
    step("hold_exit", 1'b1, 1'b0, 1'b0);
    step("held_in_play", 1'b1, 1'b0, 1'b0);
    step("release", 1'b0, 1'b0, 1'b0);

    // simultaneous presses cancel
    step("both", 1'b1, 1'b1, 1'b0);
    step("both_rel", 1'b0, 1'b0, 1'b0);

    // resetround wins over a press in the same cycle
    press_r("r_to1");
    step("rr_vs_press", 1'b0, 1'b1, 1'b1);
    step("rr_rel", 1'b0, 1'b0, 1'b0);

    // right wins two rounds -> game over
    for (int rnd = 0; rnd < 2; rnd++) begin
      press_r("r_a");
      press_r("r_b");
      press_r("r_win");
      step("r_hold_exit", 1'b0, 1'b0, 1'b0);
    end
    step("go_l", 1'b1, 1'b0, 1'b0);
    step("go_r_rr", 1'b0, 1'b1, 1'b1);
    step("go_idle", 1'b0, 1'b0, 1'b0);

    // reset out of game over, sampled before any clock edge
    rst = 1'b1;
    #1;
    model_reset();
    sb.push_back(model_out("go_reset"));
    compare5();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    step("post_reset", 1'b0, 1'b0, 1'b0);

    // async reset in the middle of HOLD
    press_l("h_a");
    press_l("h_b");
    step("h_win", 1'b1, 1'b0, 1'b0);
    l5 = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    sb.push_back(model_out("hold_async_reset"));
    compare5();
    #1 rst = 1'b0;
    step("after_async", 1'b1, 1'b0, 1'b0);
    step("after_async_rel", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
